// File: rtl/spi_sram_responder_if.sv
// SPI target pin bundle plus status outputs of the SPI-to-SRAM responder.
// Slave side is the responder; master side is the initiator driving cs_n/mosi.
interface spi_sram_responder_if;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       frame_active;
  logic       cmd_err;
  logic       wr_strobe;
  logic [4:0] cur_addr;

  modport slave (
    input  cs_n, mosi,
    output miso, frame_active, cmd_err, wr_strobe, cur_addr
  );

  modport master (
    output cs_n, mosi,
    input  miso, frame_active, cmd_err, wr_strobe, cur_addr
  );
endinterface

// File: rtl/spi_sram_responder.sv
// SPI target decoding READ(0x03)/WRITE(0x02) frames on sck into a 32x8 register file.
// Optional macro SPI_SRAM_AUTOINC_EN: pointer advances after every data byte (burst mode).
module spi_sram_responder (
  input  logic                        sck,
  input  logic                        rst_n,
  spi_sram_responder_if.slave         bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [6:0] r_tx;
  logic       r_is_read;
  logic [4:0] r_addr;
  logic       r_miso;
  logic       r_cmd_err;
  logic       r_wr_strobe;
  logic [7:0] r_mem [32];

  logic [7:0] w_byte;
  logic [4:0] w_next_addr;

  // Byte completed by the bit being sampled on this edge.
  assign w_byte = {r_shift, bus.mosi};

`ifdef SPI_SRAM_AUTOINC_EN
  assign w_next_addr = r_addr + 5'd1;
`else
  assign w_next_addr = r_addr;
`endif

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_tx        <= 7'd0;
      r_is_read   <= 1'b0;
      r_addr      <= 5'd0;
      r_miso      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_wr_strobe <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      r_cmd_err   <= 1'b0;
      r_wr_strobe <= 1'b0;
      if (bus.cs_n) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_shift   <= 7'd0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= 3'd1;
            r_miso    <= 1'b0;
            r_state   <= S_CMD;
          end
          S_CMD: begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_byte == 8'h03) begin
                r_is_read <= 1'b1;
                r_state   <= S_ADDR;
              end else if (w_byte == 8'h02) begin
                r_is_read <= 1'b0;
                r_state   <= S_ADDR;
              end else begin
                r_cmd_err <= 1'b1;
                r_state   <= S_IGNORE;
              end
            end
          end
          S_ADDR: begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr <= w_byte[4:0];
              if (r_is_read) begin
                // First data bit leaves on the same edge that samples address bit 0.
                r_miso  <= r_mem[w_byte[4:0]][7];
                r_tx    <= r_mem[w_byte[4:0]][6:0];
                r_state <= S_RD;
              end else begin
                r_state <= S_WR;
              end
            end
          end
          S_RD: begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr <= w_next_addr;
              r_miso <= r_mem[w_next_addr][7];
              r_tx   <= r_mem[w_next_addr][6:0];
            end else begin
              r_miso <= r_tx[6];
              r_tx   <= {r_tx[5:0], 1'b0};
            end
          end
          S_WR: begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_mem[r_addr] <= w_byte;
              r_wr_strobe   <= 1'b1;
              r_addr        <= w_next_addr;
            end
          end
          S_IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.miso         = r_miso;
  assign bus.frame_active = (r_state != S_IDLE);
  assign bus.cmd_err      = r_cmd_err;
  assign bus.wr_strobe    = r_wr_strobe;
  assign bus.cur_addr     = r_addr;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: reference memory model feeds a read-data scoreboard.
// Build with or without SPI_SRAM_AUTOINC_EN; the model follows the same macro.
module tb_spi_sram_responder;
`ifdef SPI_SRAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic sck;
  logic rst_n;
  spi_sram_responder_if bus ();

  spi_sram_responder dut (
    .sck   (sck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_mem [32];
  logic [7:0] sb [$];

  initial sck = 1'b0;
  always #5 sck = ~sck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  task automatic spi_edge(input logic b);
    @(negedge sck);
    bus.cs_n = 1'b0;
    bus.mosi = b;
    @(posedge sck);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_edge(b[i]);
  endtask

  task automatic end_frame();
    @(negedge sck);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    @(posedge sck);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    logic [4:0] p;
    logic [7:0] got;
    logic [7:0] exp;
    p = a[4:0];
    for (int b = 0; b < n; b++) begin
      sb.push_back(exp_mem[p]);
      p = AUTOINC ? p + 5'd1 : p;
    end
    send_byte(8'h03);
    n_checks++;
    if (bus.frame_active !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_frame_active: actual=%b required=1", bus.frame_active);
    end
    for (int i = 7; i >= 1; i--) spi_edge(a[i]);
    n_checks++;
    if (bus.miso !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_miso_before_data: actual=%b required=0", bus.miso);
    end
    spi_edge(a[0]);
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (!(b == 0 && i == 7)) spi_edge(1'b0);
        got[i] = bus.miso;
      end
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL rd_data addr=%0h byte=%0d: actual=%02h required=%02h", a, b, got, exp);
      end
    end
    end_frame();
    n_checks++;
    if (bus.frame_active !== 1'b0 || bus.miso !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_end_frame: actual fa=%b miso=%b required fa=0 miso=0",
               bus.frame_active, bus.miso);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
    logic [4:0] p;
    logic [7:0] d;
    send_byte(8'h02);
    send_byte(a);
    p = a[4:0];
    for (int b = 0; b < n; b++) begin
      d = (b == 0) ? d0 : d1;
      for (int i = 7; i >= 0; i--) begin
        spi_edge(d[i]);
        n_checks++;
        if (bus.wr_strobe !== (i == 0)) begin
          n_errors++;
          $display("FAIL wr_strobe byte=%0d bit=%0d: actual=%b required=%b",
                   b, i, bus.wr_strobe, (i == 0));
        end
      end
      exp_mem[p] = d;
      p = AUTOINC ? p + 5'd1 : p;
    end
    n_checks++;
    if (bus.cur_addr !== p) begin
      n_errors++;
      $display("FAIL wr_cur_addr: actual=%02h required=%02h", bus.cur_addr, p);
    end
    end_frame();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.miso !== 1'b0 || bus.frame_active !== 1'b0 || bus.cmd_err !== 1'b0 ||
        bus.wr_strobe !== 1'b0 || bus.cur_addr !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: actual miso=%b fa=%b err=%b wr=%b addr=%02h required all 0",
               bus.miso, bus.frame_active, bus.cmd_err, bus.wr_strobe, bus.cur_addr);
    end
    clear_model();
    repeat (2) @(posedge sck);
    @(negedge sck);
    rst_n = 1'b1;
  endtask

  task automatic test_read_after_reset();
    do_read(8'h05, 1);
  endtask

  task automatic test_write_read();
    do_write(8'h0A, 8'hA5, 8'h00, 1);
    do_read(8'hEA, 1);
  endtask

  task automatic test_burst_wrap();
    do_write(8'h1F, 8'h11, 8'h22, 2);
    do_read(8'h1F, 2);
  endtask

  task automatic test_bad_opcode();
    logic [7:0] op;
    op = 8'h9F;
    for (int i = 7; i >= 0; i--) begin
      spi_edge(op[i]);
      n_checks++;
      if (bus.cmd_err !== (i == 0)) begin
        n_errors++;
        $display("FAIL cmd_err bit=%0d: actual=%b required=%b", i, bus.cmd_err, (i == 0));
      end
    end
    send_byte(8'h0A);
    for (int i = 7; i >= 0; i--) begin
      spi_edge(i[0]);
      n_checks++;
      if (bus.miso !== 1'b0 || bus.wr_strobe !== 1'b0 || bus.cmd_err !== 1'b0) begin
        n_errors++;
        $display("FAIL ignore_quiet bit=%0d: actual miso=%b wr=%b err=%b required 0",
                 i, bus.miso, bus.wr_strobe, bus.cmd_err);
      end
    end
    end_frame();
    do_read(8'h0A, 1);
  endtask

  task automatic test_partial_write();
    do_write(8'h03, 8'h3C, 8'h00, 1);
    send_byte(8'h02);
    send_byte(8'h03);
    for (int i = 0; i < 5; i++) begin
      spi_edge(1'b1);
      n_checks++;
      if (bus.wr_strobe !== 1'b0) begin
        n_errors++;
        $display("FAIL partial_wr_strobe bit=%0d: actual=%b required=0", i, bus.wr_strobe);
      end
    end
    end_frame();
    do_read(8'h03, 1);
  endtask

  task automatic test_reset_mid_read();
    send_byte(8'h03);
    send_byte(8'h0A);
    n_checks++;
    if (bus.miso !== exp_mem[5'h0A][7]) begin
      n_errors++;
      $display("FAIL midrd_first_bit: actual=%b required=%b", bus.miso, exp_mem[5'h0A][7]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.miso !== 1'b0 || bus.frame_active !== 1'b0 || bus.cur_addr !== 5'd0) begin
      n_errors++;
      $display("FAIL midrd_reset: actual miso=%b fa=%b addr=%02h required 0 0 00",
               bus.miso, bus.frame_active, bus.cur_addr);
    end
    clear_model();
    @(negedge sck);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    @(posedge sck);
    @(negedge sck);
    rst_n = 1'b1;
    do_read(8'h0A, 1);
    do_read(8'h1F, 1);
  endtask

  initial begin
    rst_n    = 1'b1;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    clear_model();
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_burst_wrap();
    test_bad_opcode();
    test_partial_write();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
# spi_sram_responder

SPI target-side responder for the SPI-to-SRAM interface: decodes serial READ/WRITE frames clocked on `sck` and serves a 32×8 register-file SRAM. Pairs with the initiator-side bit sequencing (5-bit, MSB-first bit/address counting on `sck`). It is a stand-alone slave that a testbench or the initiator path drives directly.

## Interface
- No parameters; data width 8 and depth 32 (5-bit address) are fixed.
- `sck`  in  1  SPI clock, sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cs_n`  in  1  chip select, active low, sampled on rising `sck`.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first; 0 when not returning read data.
- `frame_active`  out  1  high while state ≠ IDLE.
- `cmd_err`  out  1  one-cycle pulse on unrecognised opcode.
- `wr_strobe`  out  1  one-cycle pulse when a byte is committed to memory.
- `cur_addr`  out  5  current memory pointer.

## Operation
- Reset (async, `rst_n`=0): state IDLE, bit counter 0, `cur_addr`=0, all 32 memory bytes 0x00, `miso`=0, `frame_active`=0, `cmd_err`=0, `wr_strobe`=0.
- Any rising `sck` with `cs_n`=1: state → IDLE, bit counter cleared, `miso`=0; partial shift data discarded; memory and `cur_addr` keep their values. Takes priority over all other decoding.
- States: IDLE, CMD, ADDR, RD, WR, IGNORE. 3-bit bit counter, wraps 7→0 every byte.
- IDLE: first rising edge with `cs_n`=0 samples opcode bit 7 and enters CMD.
- CMD: 8 bits shifted MSB first. On the 8th bit: 0x03 → ADDR (read), 0x02 → ADDR (write), any other value → IGNORE with `cmd_err`=1 for that cycle.
- ADDR: 8 bits shifted; low 5 bits loaded into `cur_addr`, upper 3 ignored. On the 8th bit, a read goes to RD, loads mem[addr] into the tx shifter, and drives `miso`=bit 7 on that same edge. A write goes to WR.
- RD: each rising edge drives the next bit. After bit 0 has been driven, the pointer advances and the next byte's bit 7 is driven on the following edge. The burst is unbounded.
- WR: 8 bits shifted in. On the 8th bit, mem[`cur_addr`] ← byte, `wr_strobe`=1 for one cycle, pointer advances. A byte left incomplete at `cs_n` deassertion is never written.
- IGNORE: `miso`=0; remains until `cs_n`=1.
- Pointer advance: `cur_addr` + 1 modulo 32 (31 → 0).

## Timing
- All outputs are registered on rising `sck`; there are no combinational paths from inputs to outputs.
- Initiator samples `miso` on falling `sck`; `miso` is stable for a full cycle after each rising edge.
- Read latency: first data bit appears on the edge that samples address bit 0, i.e. edge 16 of the frame (edges counted from 1).
- Write commit: on edge 24 for the first byte, then every 8 edges.
- `cs_n` deassertion requires at least one rising `sck` with `cs_n`=1 between frames for the return to IDLE.
- Reset asserted mid-frame aborts the frame immediately and clears memory.

## Configuration
- `SPI_SRAM_AUTOINC_EN` defined: pointer advances after every data byte in RD and WR, as specified above (burst mode).
- Not defined: `cur_addr` stays fixed for the whole frame. Repeated read bytes return the same location. Repeated write bytes overwrite the same location; `wr_strobe` still pulses per byte.

## Test plan
- Reset, then READ 0x03 addr 0x05 → 8 `miso` bits 0x00, `frame_active`=1 during the frame, 0 after `cs_n`=1.
- WRITE 0x02 addr 0x0A data 0xA5, then READ addr 0x0A → `wr_strobe` pulses on edge 24; readback 0xA5; `cur_addr`=0x0B after the write (with AUTOINC).
- Burst WRITE addr 0x1F data 0x11,0x22, then READ addr 0x1F for two bytes → 0x11,0x22 (wrap 31→0); without AUTOINC → mem[0x1F]=0x22, read returns 0x22,0x22.
- Opcode 0x9F → `cmd_err` pulse on edge 8; `miso` stays 0; a subsequent write byte has no memory effect.
- WRITE with `cs_n` raised after 5 data bits → no `wr_strobe`; target byte unchanged; next frame decodes normally.
- Assert `rst_n`=0 mid-RD burst → `miso`=0 and `frame_active`=0 immediately; prior written bytes read back 0x00.
